// File: rtl/divider_nb_if.sv
// Handshake and result bundle for divider_nb. The requester drives start/A/B.
// The divider returns Quotient/Remainder/ready/div_by_zero.
interface divider_nb_if #(
  parameter int nb = 8
) ();

  logic          start;
  logic [nb-1:0] A;
  logic [nb-1:0] B;
  logic [nb-1:0] Quotient;
  logic [nb-1:0] Remainder;
  logic          ready;
  logic          div_by_zero;

  modport master (
    output start,
    output A,
    output B,
    input  Quotient,
    input  Remainder,
    input  ready,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output Quotient,
    output Remainder,
    output ready,
    output div_by_zero
  );

endinterface

// File: rtl/divider_nb.sv
// Multi-cycle restoring divider: nb RUN steps, one FIX step, then a publish edge.
// Define DIVIDER_NB_SIGNED_EN for two's-complement operands; the default build is unsigned.
module divider_nb #(
  parameter int nb = 8
) (
  input logic         clk,
  input logic         rst_n,
  divider_nb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [nb-1:0] dvd_q, dvd_d;
  logic [nb-1:0] dvs_q, dvs_d;
  logic [nb-1:0] rem_q, rem_d;
  logic [nb-1:0] quo_q, quo_d;
  logic          zero_q, zero_d;
  logic [nb-1:0] quotient_q, quotient_d;
  logic [nb-1:0] remainder_q, remainder_d;
  logic          ready_q, ready_d;
  logic          dbz_q, dbz_d;

  logic [nb-1:0] mag_a, mag_b;
  logic [nb-1:0] quo_fix, rem_fix;
  logic [nb:0]   shifted, diff;

`ifdef DIVIDER_NB_SIGNED_EN
  logic sign_a_q, sign_a_d;
  logic sign_b_q, sign_b_d;

  // |-2^(nb-1)| is 2^(nb-1), which still fits in an nb-bit unsigned magnitude.
  assign mag_a = bus.A[nb-1] ? -bus.A : bus.A;
  assign mag_b = bus.B[nb-1] ? -bus.B : bus.B;

  assign quo_fix = zero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -quo_q : quo_q);
  assign rem_fix = sign_a_q ? -rem_q : rem_q;
`else
  assign mag_a = bus.A;
  assign mag_b = bus.B;

  assign quo_fix = zero_q ? '1 : quo_q;
  assign rem_fix = rem_q;
`endif

  // Restoring step: a negative difference shows up as a set top bit.
  assign shifted = {rem_q, dvd_q[nb-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ready_d     = ready_q;
    dbz_d       = dbz_q;
`ifdef DIVIDER_NB_SIGNED_EN
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
`endif

    if (bus.start) begin
      state_d     = RUN;
      cnt_d       = '0;
      dvd_d       = mag_a;
      dvs_d       = mag_b;
      rem_d       = '0;
      quo_d       = '0;
      zero_d      = (bus.B == '0);
      quotient_d  = '0;
      remainder_d = '0;
      ready_d     = 1'b0;
      dbz_d       = 1'b0;
`ifdef DIVIDER_NB_SIGNED_EN
      sign_a_d    = bus.A[nb-1];
      sign_b_d    = bus.B[nb-1];
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          dvd_d = {dvd_q[nb-2:0], 1'b0};
          if (!diff[nb]) begin
            rem_d = diff[nb-1:0];
            quo_d = {quo_q[nb-2:0], 1'b1};
          end else begin
            rem_d = shifted[nb-1:0];
            quo_d = {quo_q[nb-2:0], 1'b0};
          end
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'(nb - 1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          quo_d   = quo_fix;
          rem_d   = rem_fix;
          state_d = DONE;
        end
        DONE: begin
          // First DONE cycle publishes the fixed-up result; afterwards everything holds.
          if (!ready_q) begin
            quotient_d  = quo_q;
            remainder_d = rem_q;
            ready_d     = 1'b1;
            dbz_d       = zero_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef DIVIDER_NB_SIGNED_EN
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
      dbz_q       <= dbz_d;
`ifdef DIVIDER_NB_SIGNED_EN
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
`endif
    end
  end

  assign bus.Quotient    = quotient_q;
  assign bus.Remainder   = remainder_q;
  assign bus.ready       = ready_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_nb.sv
// Randomized bench for divider_nb (nb=8) against an integer-arithmetic reference.
// Follows DIVIDER_NB_SIGNED_EN for the operand interpretation.
module tb_divider_nb;

  localparam int NB = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  divider_nb_if #(.nb(NB)) bus ();

  divider_nb #(.nb(NB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, which truncates toward zero.
  task automatic computeExpected(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] r, output logic z);
    int na;
    int nd;
`ifdef DIVIDER_NB_SIGNED_EN
    na = $signed(a);
    nd = $signed(b);
`else
    na = int'(a);
    nd = int'(b);
`endif
    if (nd == 0) begin
      q = 8'hFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 8'(na / nd);
      r = 8'(na % nd);
      z = 1'b0;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 8'($urandom);
    bus.B     = 8'($urandom);
  endtask

  task automatic runDivision(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq;
    logic [7:0] er;
    logic       ez;
    int         lat;
    computeExpected(a, b, eq, er, ez);
    applyStimulus(a, b);
    lat = 0;
    while (!bus.ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, 10);
    checkOutput("quotient", bus.Quotient, eq);
    checkOutput("remainder", bus.Remainder, er);
    checkOutput("div_by_zero", bus.div_by_zero, ez);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_ready"}, bus.ready, 0);
    checkOutput({tag, "_quotient"}, bus.Quotient, 0);
    checkOutput({tag, "_remainder"}, bus.Remainder, 0);
    checkOutput({tag, "_dbz"}, bus.div_by_zero, 0);
  endtask

  logic [7:0] dirA [10] = '{8'd100, 8'h9C, 8'd100, 8'h80, 8'd5, 8'd200, 8'hFF, 8'd0, 8'hFF, 8'h80};
  logic [7:0] dirB [10] = '{8'd7, 8'd7, 8'hF9, 8'hFF, 8'd0, 8'd3, 8'h10, 8'd9, 8'd1, 8'd0};

  initial begin
    logic [7:0] hq;
    logic [7:0] hr;
    logic [7:0] ra;
    logic [7:0] rb;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    checkZero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkZero("idle");

    for (int i = 0; i < 10; i++) begin
      runDivision(dirA[i], dirB[i]);
    end

    // Result must hold while start stays low and A/B wander.
    runDivision(8'd100, 8'd7);
    hq = bus.Quotient;
    hr = bus.Remainder;
    repeat (5) begin
      bus.A = 8'($urandom);
      bus.B = 8'($urandom);
      @(negedge clk);
    end
    checkOutput("hold_ready", bus.ready, 1);
    checkOutput("hold_quotient", bus.Quotient, 8'd14);
    checkOutput("hold_remainder", bus.Remainder, 8'd2);
    checkOutput("hold_stable", {hq, hr}, {bus.Quotient, bus.Remainder});

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      runDivision(ra, rb);
    end

    // Restart at counter 3: only the second operation may report.
    applyStimulus(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    runDivision(8'd50, 8'd5);

    // Reset in the middle of RUN.
    applyStimulus(8'd100, 8'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkZero("rst_run");
    repeat (14) @(negedge clk);
    checkZero("rst_run_idle");

    // Reset while a result is displayed.
    runDivision(8'd200, 8'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkZero("rst_done");

    // Reset wins over a simultaneous start.
    rst_n     = 1'b0;
    bus.A     = 8'd100;
    bus.B     = 8'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (14) @(negedge clk);
    checkZero("rst_start");

    runDivision(8'd100, 8'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
